// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between an operand source and the serial adder.
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;

    modport master (
        output i_start, i_a, i_b, i_cin,
        input  o_busy, o_done, o_sum, o_cout
    );

    modport slave (
        input  i_start, i_a, i_b, i_cin,
        output o_busy, o_done, o_sum, o_cout
    );

endinterface

// File: rtl/fa.sv
// Single-bit full-adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop, LSB first,
// one bit per clock. Result and carry-out are valid while done is high.
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_s;
    logic             w_c;

    fa u_fa (
        .a    (r_sha[0]),
        .b    (r_shb[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // busy/done are kept as flops updated alongside the state, so no input reaches them combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sha   <= '0;
            r_shb   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_sha   <= bus.i_a;
                        r_shb   <= bus.i_b;
                        r_carry <= bus.i_cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
                    r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
                    r_carry <= w_c;
                    // The counter parks on the last bit index instead of wrapping
                    if (r_cnt == LAST) begin
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_sum  = r_sum;
    assign bus.o_cout = r_cout;

endmodule
